sdiv32: RTL

Sequential 32-bit divider, the inverse companion to the team's serial-parallel multiplier: same start/done handshake, one quotient bit per clock via a restoring shift-subtract loop on operand magnitudes, then one sign-fixup cycle. Signed (truncate toward zero) or unsigned, selected per operation. Defined results for divide-by-zero and signed overflow, so downstream ALU logic needs no special casing.

---
 rtl/sdiv32_pkg.sv | 14 +
 rtl/sdiv32_if.sv | 27 ++
 rtl/sdiv32_div_step.sv | 17 +
 rtl/sdiv32.sv | 101 ++++++++++
 4 files changed

// File: rtl/sdiv32_pkg.sv
// Shared types and constants for the sequential divider.
package sdiv32_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        FIXUP   = 2'b10,
        DONE    = 2'b11
    } state_t;

endpackage

// File: rtl/sdiv32_if.sv
// Request/result bundle between the divider and its client.
interface sdiv32_if
    import sdiv32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] dd;
    logic [WIDTH-1:0] dv;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, op, dd, dv,
        input  q, r, busy, done, dbz, ovf
    );

    modport slave (
        input  start, op, dd, dv,
        output q, r, busy, done, dbz, ovf
    );
endinterface

// File: rtl/sdiv32_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits. Purely combinational.
module div_step
    import sdiv32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0] rem,
    input  logic [WIDTH:0] div,
    output logic [WIDTH:0] rem_next,
    output logic           qbit
);
    always_comb begin
        qbit     = (rem >= div);
        rem_next = qbit ? (rem - div) : rem;
    end
endmodule

// File: rtl/sdiv32.sv
// Sequential signed/unsigned divider, one quotient bit per clock plus a sign
// fixup cycle; start is ignored while busy, results held in DONE.
module sdiv32
    import sdiv32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    sdiv32_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, zdiv, ovf_op;
    logic [WIDTH-1:0] quo, dd_raw;
    logic [WIDTH:0]   rem, div, rem_sh, rem_next;
    logic             qbit, accept;
    logic [WIDTH-1:0] q_reg, r_reg;
    logic             dbz_reg, ovf_reg;

    // W-bit two's-complement negate of the most negative value is still
    // 2^(W-1) when read unsigned, so the magnitude is exact without a sign bit.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign rem_sh = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_sh),
        .div      (div),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (bus.start)   state_next = RUNNING;
            RUNNING:    if (cnt == LAST) state_next = FIXUP;
            FIXUP:                       state_next = DONE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUNNING) || (state == FIXUP);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            zdiv    <= 1'b0;
            ovf_op  <= 1'b0;
            quo     <= '0;
            dd_raw  <= '0;
            rem     <= '0;
            div     <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            neg_q  <= bus.op & (bus.dd[WIDTH-1] ^ bus.dv[WIDTH-1]);
            neg_r  <= bus.op & bus.dd[WIDTH-1];
            zdiv   <= (bus.dv == '0);
            ovf_op <= bus.op && (bus.dd == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.dv == '1);
            quo    <= mag(bus.dd, bus.op);
            dd_raw <= bus.dd;
            rem    <= '0;
            div    <= {1'b0, mag(bus.dv, bus.op)};
        end else if (state == RUNNING) begin
            rem <= rem_next;
            quo <= {quo[WIDTH-2:0], qbit};
            cnt <= cnt + 1'b1;
        end else if (state == FIXUP) begin
            q_reg   <= zdiv ? '1 : (neg_q ? (~quo + 1'b1) : quo);
            r_reg   <= zdiv ? dd_raw : (neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0]);
            dbz_reg <= zdiv;
            ovf_reg <= ovf_op & ~zdiv;
        end
    end

    assign bus.q   = q_reg;
    assign bus.r   = r_reg;
    assign bus.dbz = dbz_reg;
    assign bus.ovf = ovf_reg;
endmodule
